// File: rtl/multiplier_pkg.sv
// Shared execute-stage definitions for the iterative multiplier and the
// divider: functional-unit codes, multiply op codes, FSM states and the
// radix-4 Booth digit encoding with its decoder.
package multiplier_pkg;

    // Functional-unit type codes presented by the issue logic.
    typedef enum logic [3:0] {
        T_NONE = 4'd0,
        TMUL   = 4'd1,
        TDIV   = 4'd2
    } fu_type_e;

    // Multiply op codes; any other subtype value is treated as MULW.
    typedef enum logic [4:0] {
        MULW   = 5'd0,
        MULHW  = 5'd1,
        MULHWU = 5'd2
    } mul_op_e;

    // Iterative unit states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    // Radix-4 Booth digit selecting the partial product multiple.
    typedef enum logic [2:0] {
        BOOTH_ZERO = 3'd0,
        BOOTH_POS1 = 3'd1,
        BOOTH_POS2 = 3'd2,
        BOOTH_NEG1 = 3'd3,
        BOOTH_NEG2 = 3'd4
    } booth_e;

    // 17 two-bit digits cover the 34-bit extended multiplier; the counter
    // value of the final iteration.
    localparam logic [4:0] LAST_ITER = 5'd16;

    // Map the Booth window {Q[1:0], q_m1} to its digit.
    function automatic booth_e booth_decode(input logic [2:0] win);
        booth_e dig;
        case (win)
            3'b001, 3'b010: dig = BOOTH_POS1;
            3'b011:         dig = BOOTH_POS2;
            3'b100:         dig = BOOTH_NEG2;
            3'b101, 3'b110: dig = BOOTH_NEG1;
            default:        dig = BOOTH_ZERO;
        endcase
        return dig;
    endfunction

endpackage

// File: rtl/multiplier_if.sv
// Issue/stall/flush bundle between the execute-stage pipeline and the
// multiplier. The pipeline drives through the master modport, the
// multiplier consumes through the slave modport.
interface multiplier_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       pipeline_multiplier_type;
    logic [4:0]       pipeline_multiplier_subtype;
    logic             pipeline_multiplier_stall;
    logic             pipeline_multiplier_flush;
    logic [WIDTH-1:0] pipeline_multiplier_din1;
    logic [WIDTH-1:0] pipeline_multiplier_din2;
    logic             multiplier_pipeline_stall;
    logic [WIDTH-1:0] multiplier_pipeline_dout;

    modport master (
        output pipeline_multiplier_type,
        output pipeline_multiplier_subtype,
        output pipeline_multiplier_stall,
        output pipeline_multiplier_flush,
        output pipeline_multiplier_din1,
        output pipeline_multiplier_din2,
        input  multiplier_pipeline_stall,
        input  multiplier_pipeline_dout
    );

    modport slave (
        input  pipeline_multiplier_type,
        input  pipeline_multiplier_subtype,
        input  pipeline_multiplier_stall,
        input  pipeline_multiplier_flush,
        input  pipeline_multiplier_din1,
        input  pipeline_multiplier_din2,
        output multiplier_pipeline_stall,
        output multiplier_pipeline_dout
    );
endinterface

// File: rtl/multiplier_booth_sel.sv
// Radix-4 Booth partial product selector: turns a 3-bit window of the
// multiplier and the extended multiplicand into 0, +-M or +-2M, already
// sign-extended to the accumulator width.
module multiplier_booth_sel
    import multiplier_pkg::*;
#(
    parameter int EXT_W = 34
) (
    input  logic [2:0]              win,
    input  logic signed [EXT_W-1:0] m,
    output logic signed [EXT_W+1:0] pp
);

    localparam int ACC_W = EXT_W + 2;

    booth_e                  dig;
    logic signed [ACC_W-1:0] m_x;
    logic signed [ACC_W-1:0] m2_x;

    // Select the multiple chosen by the decoded Booth digit.
    always_comb begin
        dig  = booth_decode(win);
        m_x  = {{2{m[EXT_W-1]}}, m};
        m2_x = {m[EXT_W-1], m, 1'b0};
        case (dig)
            BOOTH_POS1: pp = m_x;
            BOOTH_POS2: pp = m2_x;
            BOOTH_NEG1: pp = -m_x;
            BOOTH_NEG2: pp = -m2_x;
            default:    pp = '0;
        endcase
    end

endmodule

// File: rtl/multiplier.sv
// Iterative radix-4 Booth multiplier for MUL.W / MULH.W / MULH.WU.
// Accepts an op from IDLE, retires two multiplier bits per cycle for 17
// cycles (or finishes at once when an operand is zero), then holds the
// product in DONE until the pipeline releases its stall.
module multiplier
    import multiplier_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rstn,
    multiplier_if.slave pif
);

    // Operands are extended by two bits so unsigned 32-bit values stay
    // positive and the final Booth digit sees a proper sign bit.
    localparam int EXT_W = WIDTH + 2;
    localparam int ACC_W = WIDTH + 4;
    localparam int SH_W  = ACC_W + EXT_W + 1;
    localparam int P_W   = 2 * WIDTH;

    mul_state_e              state_q, state_d;
    logic [4:0]              mode_q, mode_d;
    logic signed [EXT_W-1:0] m_q, m_d;
    logic [EXT_W-1:0]        q_q, q_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    qm1_q, qm1_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [P_W-1:0]          prod_q, prod_d;

    logic                    exe;
    logic                    unsigned_op;
    logic signed [EXT_W-1:0] ext1;
    logic signed [EXT_W-1:0] ext2;
    logic signed [ACC_W-1:0] pp;
    logic signed [ACC_W-1:0] sum;
    logic signed [SH_W-1:0]  shifted;

    multiplier_booth_sel #(
        .EXT_W (EXT_W)
    ) u_booth_sel (
        .win (({q_q[1:0], qm1_q})),
        .m   (m_q),
        .pp  (pp)
    );

    // Issue decode, operand extension and one Booth add-and-shift step.
    always_comb begin
        exe         = (pif.pipeline_multiplier_type == TMUL) && !pif.pipeline_multiplier_stall;
        unsigned_op = (pif.pipeline_multiplier_subtype == MULHWU);
        ext1        = {{2{pif.pipeline_multiplier_din1[WIDTH-1] & ~unsigned_op}},
                       pif.pipeline_multiplier_din1};
        ext2        = {{2{pif.pipeline_multiplier_din2[WIDTH-1] & ~unsigned_op}},
                       pif.pipeline_multiplier_din2};
        sum         = acc_q + pp;
        shifted     = $signed({sum, q_q, qm1_q}) >>> 2;
    end

    // Next-state and datapath update; flush overrides everything like reset.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        m_d     = m_q;
        q_d     = q_q;
        acc_d   = acc_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            ST_IDLE: begin
                if (exe) begin
                    mode_d = pif.pipeline_multiplier_subtype;
                    m_d    = ext1;
                    q_d    = ext2;
                    acc_d  = '0;
                    qm1_d  = 1'b0;
                    cnt_d  = '0;
                    if ((pif.pipeline_multiplier_din1 == '0) ||
                        (pif.pipeline_multiplier_din2 == '0)) begin
                        prod_d  = '0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d = shifted[SH_W-1 -: ACC_W];
                q_d   = shifted[EXT_W:1];
                qm1_d = shifted[0];
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    prod_d  = shifted[P_W:1];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!pif.pipeline_multiplier_stall) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pif.pipeline_multiplier_flush) begin
            state_d = ST_IDLE;
            mode_d  = '0;
            acc_d   = '0;
            q_d     = '0;
            qm1_d   = 1'b0;
            cnt_d   = '0;
            prod_d  = '0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            m_q     <= m_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    // Busy while calculating, and combinationally on an accepted issue;
    // result half selected by the latched op.
    always_comb begin
        case (state_q)
            ST_IDLE: pif.multiplier_pipeline_stall = exe;
            ST_CALC: pif.multiplier_pipeline_stall = 1'b1;
            default: pif.multiplier_pipeline_stall = 1'b0;
        endcase
        if ((mode_q == MULHW) || (mode_q == MULHWU)) begin
            pif.multiplier_pipeline_dout = prod_q[P_W-1:WIDTH];
        end else begin
            pif.multiplier_pipeline_dout = prod_q[WIDTH-1:0];
        end
    end

endmodule
